// File: rtl/cam_capture_win.sv
// Camera pixel-capture stage: assembles sensor bus beats into pixels, skips start-up
// frames after configuration, crops to a window with sop/eop and checks frame geometry.
module cam_capture_win #(
    parameter int DIN_W       = 8,
    parameter int PIX_W       = 16,
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720,
    parameter int SKIP_FRAMES = 10,
    parameter int H_START     = 0,
    parameter int H_END       = H_ACT - 1,
    parameter int V_START     = 0,
    parameter int V_END       = V_ACT - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             href,
    input  logic [DIN_W-1:0] din,
    input  logic             cfg_done,
    output logic [PIX_W-1:0] pixel,
    output logic             vld,
    output logic             sop,
    output logic             eop,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int RATIO = PIX_W / DIN_W;
    localparam int XW    = $clog2(H_ACT + 1);
    localparam int YW    = $clog2(V_ACT + 1);
    localparam int SW    = $clog2(SKIP_FRAMES + 2);

    localparam logic [XW-1:0] X_MAX     = '1;
    localparam logic [YW-1:0] Y_MAX     = '1;
    localparam logic [XW-1:0] X_LINE    = XW'(H_ACT);
    localparam logic [YW-1:0] Y_FRAME   = YW'(V_ACT);
    localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_FRAMES);

    typedef enum logic [1:0] {IDLE, SKIP, ARM, CAP} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     skip_cnt, skip_nxt;

    logic              vsync_r0, vsync_r1, href_r0, href_r1;
    logic [DIN_W-1:0]  din_r0;
    logic              fs, href_fall;

    logic              phase;
    logic [DIN_W-1:0]  hi_beat;
    logic              pix_done, odd_end;
    logic [PIX_W-1:0]  pix_word;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y, y_line;
    logic              x_in, y_in, at_sop, at_eop;
    logic              err, eop_seen, err_pend;
    logic              line_bad, y_over, frame_bad;

    logic              asm_vld, asm_win, asm_sop, asm_eop;
    logic [PIX_W-1:0]  asm_pix;
    logic              emit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r0 <= 1'b0;
            vsync_r1 <= 1'b0;
            href_r0  <= 1'b0;
            href_r1  <= 1'b0;
            din_r0   <= '0;
        end else begin
            vsync_r0 <= vsync;
            vsync_r1 <= vsync_r0;
            href_r0  <= href;
            href_r1  <= href_r0;
            din_r0   <= din;
        end
    end

    assign fs        = vsync_r0 & ~vsync_r1;
    assign href_fall = href_r1 & ~href_r0;

    generate
        if (RATIO == 2) begin : g_pair
            assign pix_done = href_r0 & phase;
            assign pix_word = {hi_beat, din_r0};
            assign odd_end  = phase;
        end else begin : g_single
            assign pix_done = href_r0;
            assign pix_word = din_r0;
            assign odd_end  = 1'b0;
        end
    endgenerate

    // x/y are the coordinates of the pixel completing this cycle.
    assign x_in   = (int'(x) >= H_START) && (int'(x) <= H_END);
    assign y_in   = (int'(y) >= V_START) && (int'(y) <= V_END);
    assign at_sop = (int'(x) == H_START) && (int'(y) == V_START);
    assign at_eop = (int'(x) == H_END) && (int'(y) == V_END);

    // Line end is folded into y before any same-cycle fs evaluates the frame.
    assign y_line    = (href_fall && y != Y_MAX) ? y + 1'b1 : y;
    assign line_bad  = href_fall & ((x != X_LINE) | odd_end);
    assign y_over    = int'(y_line) > V_ACT;
    assign frame_bad = err | line_bad | y_over | (y_line != Y_FRAME) | ~eop_seen;

    assign emit = asm_vld & asm_win & (state == CAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_beat <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            phase <= href_r0 ? ~phase : 1'b0;
            if (href_r0 && !phase)
                hi_beat <= din_r0;
            if (href_fall)
                x <= '0;
            else if (pix_done && x != X_MAX)
                x <= x + 1'b1;
            y <= fs ? '0 : y_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            eop_seen  <= 1'b0;
            err_pend  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state != CAP || fs)
                err <= 1'b0;
            else if (line_bad || y_over)
                err <= 1'b1;
            if (fs)
                eop_seen <= 1'b0;
            else if (emit && asm_eop)
                eop_seen <= 1'b1;
            // An fs seen in ARM only opens capture; only CAP closes a frame.
            err_pend  <= (state == CAP) && cfg_done && fs && frame_bad;
            frame_err <= err_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_vld   <= 1'b0;
            asm_win   <= 1'b0;
            asm_sop   <= 1'b0;
            asm_eop   <= 1'b0;
            asm_pix   <= '0;
            vld       <= 1'b0;
            sop       <= 1'b0;
            eop       <= 1'b0;
            pixel     <= '0;
            frame_cnt <= '0;
        end else begin
            asm_vld <= pix_done;
            if (pix_done) begin
                asm_pix <= pix_word;
                asm_win <= x_in & y_in;
                asm_sop <= at_sop;
                asm_eop <= at_eop;
            end
            vld <= emit;
            sop <= emit & asm_sop;
            eop <= emit & asm_eop;
            if (emit)
                pixel <= asm_pix;
            if (emit && asm_eop)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (!cfg_done) begin
            state_nxt = IDLE;
            skip_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    skip_nxt  = '0;
                    state_nxt = (SKIP_FRAMES == 0) ? ARM : SKIP;
                end
                SKIP: if (fs) begin
                    if (skip_cnt == SKIP_LAST)
                        state_nxt = ARM;
                    else
                        skip_nxt = skip_cnt + 1'b1;
                end
                ARM:  if (fs) state_nxt = CAP;
                CAP:  state_nxt = CAP;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_win.sv
// Directed bench for cam_capture_win: 8x4 frames, 16-bit pixels from byte beats,
// crop x 2..5 / y 1..2, two start-up frames skipped.
module tb_cam_capture_win;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        cfg_done = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] pixel;
    logic        vld, sop, eop, frame_err;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int vld_cnt = 0, sop_cnt = 0, eop_cnt = 0, ferr_cnt = 0, late_vld = 0;
    int sop_cyc = 0, ferr_cyc = 0, cd_edge = 0, vs_edge = 0;
    int vld_cut = 32'h7fff_ffff;
    logic [15:0] sop_pix = '0, eop_pix = '0;
    logic [15:0] pix_q[$];

    cam_capture_win #(
        .DIN_W(8), .PIX_W(16), .H_ACT(8), .V_ACT(4), .SKIP_FRAMES(2),
        .H_START(2), .H_END(5), .V_START(1), .V_END(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
        .cfg_done(cfg_done), .pixel(pixel), .vld(vld), .sop(sop), .eop(eop),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge; cyc is the index of the rising edge that set the outputs.
    always @(negedge clk) begin
        if (vld) begin
            vld_cnt++;
            pix_q.push_back(pixel);
            if (cyc >= vld_cut) late_vld++;
            if (sop) begin sop_cnt++; sop_cyc = cyc; sop_pix = pixel; end
            if (eop) begin eop_cnt++; eop_pix = pixel; end
        end
        if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    end

    function automatic logic [15:0] exp_pix(int x, int y);
        logic [7:0] hi;
        if (x == 2 && y == 1) return 16'hABCD;
        hi = 8'((y << 4) | x);
        return {hi, ~hi};
    endfunction

    task automatic send_vsync();
        @(negedge clk); vsync = 1'b1; vs_edge = cyc + 1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(int y, int npix, bit odd, int drop_x);
        logic [15:0] p;
        for (int x = 0; x < npix; x++) begin
            p = exp_pix(x, y);
            @(negedge clk); href = 1'b1; din = p[15:8];
            if (x == drop_x) begin
                cfg_done = 1'b0;
                vld_cut = cyc + 3;
            end
            @(negedge clk); din = p[7:0];
            if (x == 2 && y == 1) cd_edge = cyc + 1;
        end
        if (odd) begin @(negedge clk); href = 1'b1; din = 8'h5A; end
        @(negedge clk); href = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(int nlines, int short_y, int short_n, int odd_y, int drop_y, int drop_x);
        send_vsync();
        for (int y = 0; y < nlines; y++)
            send_line(y, (y == short_y) ? short_n : 8, y == odd_y, (y == drop_y) ? drop_x : -1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pixel !== 16'h0000) begin errors++; $display("FAIL reset_pixel: got %h expected 0000", pixel); end
        checks++; if ({vld, sop, eop, frame_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {vld, sop, eop, frame_err}); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_skip_arm();
        int v0, s0, e0, idx;
        cfg_done = 1'b1;
        repeat (2) @(negedge clk);
        v0 = vld_cnt;
        repeat (3) send_frame(4, -1, 0, -1, -1, -1);
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL skip_silent: got %0d vld expected 0", vld_cnt - v0); end
        pix_q.delete();
        v0 = vld_cnt; s0 = sop_cnt; e0 = eop_cnt;
        send_frame(4, -1, 0, -1, -1, -1);
        checks++; if (vld_cnt - v0 !== 8) begin errors++; $display("FAIL cap_vld_count: got %0d expected 8", vld_cnt - v0); end
        checks++; if (sop_cnt - s0 !== 1) begin errors++; $display("FAIL cap_sop_count: got %0d expected 1", sop_cnt - s0); end
        checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL cap_eop_count: got %0d expected 1", eop_cnt - e0); end
        checks++; if (sop_pix !== 16'hABCD) begin errors++; $display("FAIL byte_order: got %h expected abcd", sop_pix); end
        checks++; if (sop_cyc !== cd_edge + 2) begin errors++; $display("FAIL sop_latency: got edge %0d expected %0d", sop_cyc, cd_edge + 2); end
        checks++; if (eop_pix !== 16'h25DA) begin errors++; $display("FAIL eop_pixel: got %h expected 25da", eop_pix); end
        checks++;
        if (pix_q.size() !== 8) begin
            errors++; $display("FAIL crop_size: got %0d expected 8", pix_q.size());
        end else begin
            for (int y = 1; y <= 2; y++)
                for (int x = 2; x <= 5; x++) begin
                    idx = (y - 1) * 4 + (x - 2);
                    checks++;
                    if (pix_q[idx] !== exp_pix(x, y)) begin
                        errors++; $display("FAIL crop_pixel(%0d,%0d): got %h expected %h", x, y, pix_q[idx], exp_pix(x, y));
                    end
                end
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL skip_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_short_line();
        int v0, f0;
        v0 = vld_cnt; f0 = ferr_cnt;
        send_frame(4, 3, 7, -1, -1, -1);
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL clean_close: got %0d frame_err expected 0", ferr_cnt - f0); end
        checks++; if (vld_cnt - v0 !== 8) begin errors++; $display("FAIL short_line_vld: got %0d expected 8", vld_cnt - v0); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL short_line_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_odd_beat();
        int f0;
        f0 = ferr_cnt;
        send_frame(4, -1, 0, 3, -1, -1);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL short_line_err: got %0d frame_err expected 1", ferr_cnt - f0); end
        checks++; if (ferr_cyc !== vs_edge + 2) begin errors++; $display("FAIL frame_err_timing: got edge %0d expected %0d", ferr_cyc, vs_edge + 2); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL odd_beat_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_short_frame();
        int f0, e0;
        f0 = ferr_cnt; e0 = eop_cnt;
        send_frame(3, 2, 4, -1, -1, -1);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL odd_beat_err: got %0d frame_err expected 1", ferr_cnt - f0); end
        checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL short_frame_eop: got %0d expected 0", eop_cnt - e0); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL short_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_cfg_drop();
        int f0, e0, v0;
        f0 = ferr_cnt; e0 = eop_cnt; late_vld = 0;
        send_frame(4, -1, 0, -1, 1, 3);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL short_frame_err: got %0d frame_err expected 1", ferr_cnt - f0); end
        checks++; if (late_vld !== 0) begin errors++; $display("FAIL drop_vld_stop: got %0d late vld expected 0", late_vld); end
        checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL drop_eop: got %0d expected 0", eop_cnt - e0); end
        send_vsync();
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL drop_no_err: got %0d frame_err expected 1", ferr_cnt - f0); end
        vld_cut = 32'h7fff_ffff;
        cfg_done = 1'b1;
        repeat (2) @(negedge clk);
        v0 = vld_cnt;
        repeat (3) send_frame(4, -1, 0, -1, -1, -1);
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL reskip_silent: got %0d vld expected 0", vld_cnt - v0); end
        send_frame(4, -1, 0, -1, -1, -1);
        checks++; if (vld_cnt - v0 !== 8) begin errors++; $display("FAIL recap_vld: got %0d expected 8", vld_cnt - v0); end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL recap_cnt: got %0d expected 4", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int f0, v0;
        logic [15:0] p;
        f0 = ferr_cnt;
        send_vsync();
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL recap_close: got %0d frame_err expected 0", ferr_cnt - f0); end
        send_line(0, 8, 1'b0, -1);
        for (int x = 0; x < 5; x++) begin
            p = exp_pix(x, 1);
            @(negedge clk); href = 1'b1; din = p[15:8];
            @(negedge clk); din = p[7:0];
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++; if (pixel !== 16'h0000) begin errors++; $display("FAIL midreset_pixel: got %h expected 0000", pixel); end
        checks++; if ({vld, sop, eop, frame_err} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b expected 0000", {vld, sop, eop, frame_err}); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midreset_cnt: got %0d expected 0", frame_cnt); end
        href = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        v0 = vld_cnt; f0 = ferr_cnt;
        send_frame(4, -1, 0, -1, -1, -1);
        send_vsync();
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL midreset_reskip: got %0d vld expected 0", vld_cnt - v0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midreset_err: got %0d frame_err expected 0", ferr_cnt - f0); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midreset_cnt_after: got %0d expected 0", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_skip_arm();
        test_short_line();
        test_odd_beat();
        test_short_frame();
        test_cfg_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_capture_win.md
# cam_capture_win

Parametrised successor of the camera pixel-capture stage between the OV5640 parallel port and the SDRAM write path. It assembles DIN_W-bit bus beats into PIX_W-bit pixels and discards a configurable number of start-up frames after sensor configuration. It emits only pixels inside a parameterised crop window, framed with sop/eop, and checks frame geometry with an error pulse and a frame counter.

## Interface
- DIN_W, 8, sensor data bus width.
- PIX_W, 16, output pixel width; PIX_W/DIN_W beats per pixel, legal ratios 1 or 2.
- H_ACT, 1280, expected pixels per line.
- V_ACT, 720, expected lines per frame.
- SKIP_FRAMES, 10, frames discarded after cfg_done rises (0 allowed).
- H_START/H_END, 0/H_ACT-1, inclusive crop columns (pixel index).
- V_START/V_END, 0/V_ACT-1, inclusive crop rows.

Ports:
- clk  in  1  pixel clock (buffered cmos_pclk); the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- vsync  in  1  sensor frame sync, active-high pulse between frames.
- href  in  1  sensor line valid.
- din  in  DIN_W  sensor data.
- cfg_done  in  1  sensor register configuration complete (level).
- pixel  out  PIX_W  assembled pixel, first beat in MSBs.
- vld  out  1  pixel valid.
- sop  out  1  first cropped pixel of frame, coincident with vld.
- eop  out  1  last cropped pixel of frame, coincident with vld.
- frame_err  out  1  one-cycle geometry error pulse.
- frame_cnt  out  16  count of frames fully captured (eop issued), wraps at 65535 to 0.

## Operation
- Input stage: vsync, href, and din registered once (r0). vsync delayed again (r1). Frame start fs = vsync_r0 & ~vsync_r1.
- FSM states: IDLE, SKIP, ARM, CAP.
  - IDLE: skip count cleared. On cfg_done=1, go to SKIP, or to ARM if SKIP_FRAMES=0.
  - SKIP: each fs increments the skip count. When the count reaches SKIP_FRAMES, go to ARM.
  - ARM: on fs, go to CAP.
  - CAP: capture the frame. On fs, stay in CAP and start a new frame.
  - cfg_done=0 in any state returns the FSM to IDLE on the next clock. An in-flight frame is abandoned with no eop and no frame_err.
- Beat assembly (ratio 2): a phase bit toggles on each href_r0 beat and is cleared while href_r0=0.
  - phase 0 latches din_r0 into the high half.
  - phase 1 completes the pixel as {high, din_r0}.
  - Ratio 1: every beat is a pixel.
- Counters: x counts completed pixels in a line and is cleared on href_r0 fall. y increments on href_r0 fall and is cleared on fs. Widths are $clog2(H_ACT+1) and $clog2(V_ACT+1); saturate at max.
- Emit condition: in CAP, a completed pixel with H_START ≤ x ≤ H_END and V_START ≤ y ≤ V_END raises vld.
  - sop additionally requires x=H_START and y=V_START.
  - eop additionally requires x=H_END and y=V_END.
- Geometry check runs in CAP only. A sticky err flag is set by any of:
  - a line ending with x≠H_ACT;
  - a line ending with an odd beat (ratio 2; the partial pixel is dropped);
  - y exceeding V_ACT.
- On the next fs, the frame is in error if err=1, or if y≠V_ACT, or if eop was not issued. In that case frame_err pulses and err clears.
- frame_cnt increments on each eop.

## Timing
- Reset values: pixel=0, vld=0, sop=0, eop=0, frame_err=0, frame_cnt=0, FSM=IDLE, all counters 0.
- Latency: outputs are registered. The completing beat on din at edge n gives vld/pixel high after edge n+2.
- vld is a single-cycle strobe with no backpressure; downstream must accept every vld.
- frame_err asserts 2 clocks after the vsync rising edge on the pin.
- fs and an href fall in the same cycle: the line end is processed first (y increment, check), then fs clears y.
- The first fs in ARM only starts capture; it never raises frame_err.

## Test plan
Bench parameters: H_ACT=8, V_ACT=4, ratio 2, crop x 2..5, y 1..2, SKIP_FRAMES=2.
- Reset mid-frame: assert rst_n=0 during CAP -> all outputs 0 immediately, FSM=IDLE, frame_cnt=0.
- Skip and arm: cfg_done=1, then 4 clean frames -> frames 1-2 silent, frame 3 arms only, frame 4 emits 8 vld, sop on (2,1), eop on (5,2), frame_cnt=1.
- Byte order: beats 0xAB,0xCD as pixel (2,1) -> pixel=0xABCD with sop, 2 clocks after the 0xCD beat.
- Short line: line 3 has 7 pixels -> frame data still emitted, frame_err pulses once at the next vsync, frame_cnt increments.
- Odd beat / short frame: a 17-beat line, then a frame with 3 lines and no eop -> frame_err pulses at each following fs, frame_cnt unchanged for the short frame.
- cfg_done drop: cfg_done=0 mid-CAP -> vld stops within 2 clocks, no eop, no frame_err. Re-raising cfg_done re-runs the 2-frame skip.
